// File: rtl/panda_edge_capture.sv
// Timestamps selected edges of val_i into a 32-deep first-word-fall-through FIFO; entries appear one cycle after the capture edge, a full FIFO drops new events.
// Define PANDA_EDGE_CAPTURE_DROP_COUNT_EN to build the saturating dropped-event counter; otherwise dropped_o is tied to 0.
module panda_edge_capture (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        val_i,
    input  logic        ENABLE,
    input  logic [1:0]  EDGE_SEL,
    input  logic        rd_en_i,
    output logic [32:0] dout_o,
    output logic        valid_o,
    output logic [5:0]  count_o,
    output logic        overflow_o,
    output logic [15:0] dropped_o
);
    localparam int DEPTH = 32;

    logic        r_en_prev;
    logic        r_val_prev;
    logic [31:0] r_ts;
    logic [32:0] r_mem [DEPTH];
    logic [4:0]  r_wr_ptr;
    logic [4:0]  r_rd_ptr;
    logic [5:0]  r_count;
    logic        r_overflow;

    logic w_en_rise;
    logic w_edge_match;
    logic w_event;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    always_comb begin
        w_edge_match = 1'b0;
        case (EDGE_SEL)
            2'd0:    w_edge_match = val_i & ~r_val_prev;
            2'd1:    w_edge_match = ~val_i & r_val_prev;
            default: w_edge_match = val_i ^ r_val_prev;
        endcase
    end

    // The enable-rise cycle only re-arms history, so it can never capture.
    assign w_en_rise = ENABLE & ~r_en_prev;
    assign w_event   = ENABLE & r_en_prev & w_edge_match;
    assign w_full    = (r_count == 6'(DEPTH));
    assign w_pop     = rd_en_i & (r_count != 6'd0);
    assign w_push    = w_event & (~w_full | w_pop);
    assign w_drop    = w_event & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_en_prev  <= 1'b0;
            r_val_prev <= 1'b0;
            r_ts       <= 32'd0;
            r_wr_ptr   <= 5'd0;
            r_rd_ptr   <= 5'd0;
            r_count    <= 6'd0;
            r_overflow <= 1'b0;
        end else begin
            r_en_prev  <= ENABLE;
            r_val_prev <= val_i;
            if (w_en_rise) begin
                r_ts <= 32'd0;
            end else if (ENABLE) begin
                r_ts <= r_ts + 32'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 5'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 5'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 6'd1;
                2'b01:   r_count <= r_count - 6'd1;
                default: r_count <= r_count;
            endcase
            if (w_en_rise) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !reset_i) begin
            r_mem[r_wr_ptr] <= {val_i, r_ts};
        end
    end

    assign valid_o    = (r_count != 6'd0);
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign dout_o     = valid_o ? r_mem[r_rd_ptr] : 33'd0;

`ifdef PANDA_EDGE_CAPTURE_DROP_COUNT_EN
    logic [15:0] r_dropped;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_dropped <= 16'd0;
        end else if (w_en_rise) begin
            r_dropped <= 16'd0;
        end else if (w_drop && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
        end
    end

    assign dropped_o = r_dropped;
`else
    assign dropped_o = 16'd0;
`endif

endmodule

// File: tb/tb_panda_edge_capture.sv
// Bench for panda_edge_capture: directed scenarios plus randomized traffic against a queue-based reference.
module tb_panda_edge_capture;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        val_i;
    logic        ENABLE;
    logic [1:0]  EDGE_SEL;
    logic        rd_en_i;
    logic [32:0] dout_o;
    logic        valid_o;
    logic [5:0]  count_o;
    logic        overflow_o;
    logic [15:0] dropped_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    panda_edge_capture dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .val_i      (val_i),
        .ENABLE     (ENABLE),
        .EDGE_SEL   (EDGE_SEL),
        .rd_en_i    (rd_en_i),
        .dout_o     (dout_o),
        .valid_o    (valid_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .dropped_o  (dropped_o)
    );

    // Reference state: captured entries as a plain queue.
    logic [32:0] m_q[$];
    logic [31:0] m_ts;
    logic        m_vprev;
    logic        m_enp;
    logic        m_ovf;
    int          m_drp;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic rise;
        logic evt;
        logic dir_ok;
        if (reset_i) begin
            m_q.delete();
            m_ts    = 32'd0;
            m_vprev = 1'b0;
            m_enp   = 1'b0;
            m_ovf   = 1'b0;
            m_drp   = 0;
            return;
        end
        rise   = ENABLE && !m_enp;
        dir_ok = (EDGE_SEL == 2'd0) ? val_i : (EDGE_SEL == 2'd1) ? !val_i : 1'b1;
        evt    = ENABLE && !rise && (val_i != m_vprev) && dir_ok;
        if (rd_en_i && m_q.size() > 0) void'(m_q.pop_front());
        if (evt) begin
            if (m_q.size() < 32) begin
                m_q.push_back({val_i, m_ts});
            end else begin
                m_ovf = 1'b1;
                if (m_drp < 65535) m_drp++;
            end
        end
        if (rise) begin
            m_ts  = 32'd0;
            m_ovf = 1'b0;
            m_drp = 0;
        end else if (ENABLE) begin
            m_ts = m_ts + 32'd1;
        end
        m_vprev = val_i;
        m_enp   = ENABLE;
    endtask

    task automatic compare_model();
        logic [32:0] head;
        logic [32:0] exp_drp;
        head = (m_q.size() != 0) ? m_q[0] : 33'd0;
`ifdef PANDA_EDGE_CAPTURE_DROP_COUNT_EN
        exp_drp = 33'(m_drp);
`else
        exp_drp = 33'd0;
`endif
        check("count",    33'(count_o),    33'(m_q.size()));
        check("valid",    33'(valid_o),    33'(m_q.size() != 0));
        check("dout",     dout_o,          head);
        check("overflow", 33'(overflow_o), 33'(m_ovf));
        check("dropped",  33'(dropped_o),  exp_drp);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare_model();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        ENABLE  = 1'b0;
        rd_en_i = 1'b0;
        val_i   = 1'b0;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic run_until_ts(input logic [31:0] target);
        for (int i = 0; i < 200 && m_ts != target; i++) step();
        if (m_ts != target) begin
            n_bad++;
            $display("FAIL ts_wait: timestamp %h never reached %h", m_ts, target);
        end
    endtask

    logic [32:0] exp_dropped;

    initial begin
        reset_i  = 1'b1;
        val_i    = 1'b0;
        ENABLE   = 1'b0;
        EDGE_SEL = 2'd0;
        rd_en_i  = 1'b0;
`ifdef PANDA_EDGE_CAPTURE_DROP_COUNT_EN
        exp_dropped = 33'd2;
`else
        exp_dropped = 33'd0;
`endif

        // Reset state.
        do_reset();
        check("rst_count",    33'(count_o),    33'd0);
        check("rst_valid",    33'(valid_o),    33'd0);
        check("rst_dout",     dout_o,          33'd0);
        check("rst_overflow", 33'(overflow_o), 33'd0);
        check("rst_dropped",  33'(dropped_o),  33'd0);

        // Rising-only capture: the falling edge is ignored.
        EDGE_SEL = 2'd0;
        for (int i = 0; i < 5; i++) step();
        ENABLE = 1'b1;
        step();
        run_until_ts(32'd10);
        check("rise_pre_valid", 33'(valid_o), 33'd0);
        val_i = 1'b1;
        step();
        check("rise_lat_valid", 33'(valid_o), 33'd1);
        check("rise_lat_dout",  dout_o,       33'h1_0000_000A);
        run_until_ts(32'd20);
        val_i = 1'b0;
        step();
        step();
        check("rise_count", 33'(count_o), 33'd1);
        check("rise_dout",  dout_o,       33'h1_0000_000A);

        // Both edges, a toggle every 3 cycles.
        do_reset();
        EDGE_SEL = 2'd2;
        ENABLE   = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            run_until_ts(32'(2 + 3 * k));
            val_i = ~val_i;
            step();
        end
        step();
        check("both_count", 33'(count_o), 33'd4);
        for (int k = 0; k < 4; k++) begin
            check("both_pop", dout_o, {(k % 2 == 0) ? 1'b1 : 1'b0, 32'(2 + 3 * k)});
            rd_en_i = 1'b1;
            step();
            rd_en_i = 1'b0;
        end
        check("both_empty", 33'(valid_o), 33'd0);

        // Overflow: 34 toggles, no reads.
        do_reset();
        EDGE_SEL = 2'd2;
        ENABLE   = 1'b1;
        step();
        for (int k = 0; k < 34; k++) begin
            val_i = ~val_i;
            step();
        end
        check("ovf_count",    33'(count_o),    33'd32);
        check("ovf_flag",     33'(overflow_o), 33'd1);
        check("ovf_dropped",  33'(dropped_o),  exp_dropped);
        ENABLE  = 1'b0;
        rd_en_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            check("ovf_entry", dout_o, {(k % 2 == 0) ? 1'b1 : 1'b0, 32'(k)});
            step();
        end
        rd_en_i = 1'b0;

        // Full FIFO with a simultaneous write and pop.
        do_reset();
        EDGE_SEL = 2'd2;
        ENABLE   = 1'b1;
        step();
        for (int k = 0; k < 32; k++) begin
            val_i = ~val_i;
            step();
        end
        check("fullrw_pre", 33'(count_o), 33'd32);
        val_i   = ~val_i;
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        check("fullrw_count", 33'(count_o),    33'd32);
        check("fullrw_ovf",   33'(overflow_o), 33'd0);
        ENABLE  = 1'b0;
        rd_en_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 31) check("fullrw_last", dout_o, 33'h1_0000_0020);
            step();
        end
        rd_en_i = 1'b0;

        // Reset mid-capture with a toggle on the reset edge; ENABLE held high.
        do_reset();
        EDGE_SEL = 2'd2;
        ENABLE   = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            val_i = ~val_i;
            step();
        end
        check("rstcap_pre", 33'(count_o), 33'd5);
        reset_i = 1'b1;
        val_i   = ~val_i;
        step();
        check("rstcap_count", 33'(count_o), 33'd0);
        check("rstcap_valid", 33'(valid_o), 33'd0);
        check("rstcap_dout",  dout_o,       33'd0);
        reset_i = 1'b0;
        step();
        val_i = ~val_i;
        step();
        check("rstcap_ts0", dout_o, 33'h1_0000_0000);

        // Timestamp wrap.
        do_reset();
        EDGE_SEL = 2'd2;
        ENABLE   = 1'b1;
        step();
        step();
        dut.r_ts = 32'hFFFF_FFFE;
        m_ts     = 32'hFFFF_FFFE;
        step();
        val_i = 1'b1;
        step();
        step();
        val_i = 1'b0;
        step();
        check("wrap_count", 33'(count_o), 33'd2);
        check("wrap_first", dout_o,       33'h1_FFFF_FFFF);
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        check("wrap_second", dout_o, 33'h0_0000_0001);

        // Randomized traffic.
        do_reset();
        ENABLE = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int rd_pct;
            rd_pct  = (c < 2000) ? 15 : 60;
            reset_i = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 3) ENABLE = ~ENABLE;
            if ($urandom_range(0, 49) == 0) EDGE_SEL = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) val_i = ~val_i;
            rd_en_i = ($urandom_range(0, 99) < rd_pct);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/panda_edge_capture.md
PANDA_EDGE_CAPTURE -- requirements
Module: panda_edge_capture

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port val_i, input, 1 bit: the monitored bit, synchronous to clk_i.
REQ-004 SHALL have port ENABLE, input, 1 bit: capture enable register.
REQ-005 SHALL have port EDGE_SEL, input, 2 bits: 0 = rising, 1 = falling, 2 or 3 = both edges.
REQ-006 SHALL have port rd_en_i, input, 1 bit: pop strobe for the FIFO head.
REQ-007 SHALL have port dout_o, output, 33 bits: FIFO head as {value[32], timestamp[31:0]}, first-word-fall-through.
REQ-008 SHALL have port valid_o, output, 1 bit: high while the FIFO is non-empty.
REQ-009 SHALL have port count_o, output, 6 bits: FIFO occupancy, 0..32.
REQ-010 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a capture is dropped.
REQ-011 SHALL have port dropped_o, output, 16 bits: dropped-capture count (see Configuration).

Function
REQ-012 SHALL hold a 32-bit timestamp counter that loads 0 on the cycle ENABLE is first sampled high, increments by 1 each following enabled cycle, and wraps from 0xFFFFFFFF to 0.
REQ-013 SHALL register val_i every cycle into val_prev; when ENABLE is first sampled high, val_prev SHALL be loaded from val_i and no event SHALL fire on that cycle.
REQ-014 SHALL detect an event on a clock edge where ENABLE=1, val_i differs from val_prev, and the direction matches EDGE_SEL.
REQ-015 SHALL write {val_i, timestamp} into a 32-entry FIFO at that same clock edge, so a change applied while the timestamp is N is stored with timestamp N.
REQ-016 SHALL make the written entry visible on dout_o and valid_o on the cycle after the write edge, giving 1-cycle latency.
REQ-017 SHALL pop the head on a clock edge where rd_en_i=1 and valid_o=1; rd_en_i while empty SHALL be ignored.
REQ-018 SHALL, with simultaneous write and pop, perform both; count_o SHALL stay unchanged, including when full (32).
REQ-019 SHALL, on a write while count_o=32 with no pop, drop the event, set overflow_o and leave the FIFO contents unchanged.
REQ-020 SHALL clear overflow_o only on reset_i or a 0->1 transition of ENABLE.
REQ-021 SHALL, when ENABLE=0, freeze the timestamp counter, record no events, and keep the FIFO readable.
REQ-022 SHALL, on a 0->1 transition of ENABLE, leave FIFO contents intact.
REQ-023 SHALL make an EDGE_SEL change take effect on the next clock edge.

Reset
REQ-024 SHALL, on reset_i=1 at a clock edge, clear the FIFO pointers, count_o, valid_o, overflow_o, dropped_o, the timestamp counter, val_prev and the ENABLE-history register.
REQ-025 SHALL give dout_o the value 0 while the FIFO is empty after reset.
REQ-026 SHALL, when reset_i is asserted mid-capture, discard the pending write on that edge.
REQ-027 SHALL treat ENABLE held high through reset as a fresh 0->1 transition on the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, when macro PANDA_EDGE_CAPTURE_DROP_COUNT_EN is defined, increment dropped_o by 1 per dropped event, saturating at 0xFFFF, and clear it under the same conditions as overflow_o.
REQ-029 SHALL, when PANDA_EDGE_CAPTURE_DROP_COUNT_EN is undefined, keep the dropped_o port and tie it to 0, with no counter logic.

Verification
REQ-030 SHALL cover: EDGE_SEL=0, ENABLE rises at TS 5, val_i 0->1 with block timestamp 10 and 1->0 with block timestamp 20 -> exactly one entry {1, 10}, with valid_o high one cycle later.
REQ-031 SHALL cover: EDGE_SEL=2, val_i toggles every 3 cycles for 4 toggles -> 4 entries with timestamps 3 apart and values alternating, popped in order.
REQ-032 SHALL cover: 34 toggles with no reads -> count_o=32, overflow_o=1, dropped_o=2 with the macro and 0 without; the first 32 entries are intact.
REQ-033 SHALL cover: FIFO full, a toggle arriving in the same cycle as rd_en_i=1 -> count_o stays 32, overflow_o stays 0, and the new entry is the last popped.
REQ-034 SHALL cover: reset_i pulsed with 5 entries queued and a toggle on the same edge -> count_o=0, valid_o=0, no entry written, and the timestamp restarts at 0.
REQ-035 SHALL cover: timestamp preloaded near wrap with a toggle at 0xFFFFFFFF and another 2 cycles later -> entries 0xFFFFFFFF and 0x00000001.
